// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
//   Types and constants shared by the strobed pattern generator and its
//   sample-period divider.
//
//   mode_t      : pattern selector (impulse, step, ramp, square)
//   state_t     : run-control FSM states
//   DATA_W      : default sample width
//   CNT_W       : default width of period/length/index fields
//   MIN_PERIOD  : smallest sample period the divider will honour; it keeps at
//                 least one low cycle between consecutive strobes
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

  localparam int DATA_W     = 10;
  localparam int CNT_W      = 8;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IMPULSE = 2'b00,
    STEP    = 2'b01,
    RAMP    = 2'b10,
    SQUARE  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : pattern_gen_pkg

// File: rtl/strobe_divider.sv
// -----------------------------------------------------------------------------
// strobe_divider
//   Loadable down-counter that produces one terminal-count tick every
//   `period` enabled clocks. Loading arms the counter so that the very first
//   enabled cycle after the load already ticks; afterwards ticks repeat every
//   clamped period. A disabled cycle freezes the count, so a tick that falls
//   due while disabled is delivered on the first enabled cycle.
//
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   capture `period` (clamped) and arm the first tick
//   en     in   count enable; tick can only assert while en is high
//   period in   requested period in clocks (values below MIN_PERIOD clamped)
//   tick   out  combinational terminal-count pulse
// -----------------------------------------------------------------------------
module strobe_divider #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  import pattern_gen_pkg::*;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // reload_reg holds (clamped period - 1): the count restarts there after a
  // tick so that ticks are exactly one period apart.
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] reload_reg, reload_next;

  always_comb begin
    cnt_next    = cnt_reg;
    reload_next = reload_reg;
    tick        = 1'b0;
    if (load) begin
      reload_next = (period < MIN_P) ? (MIN_P - ONE) : (period - ONE);
      // zero means "due": the first tick comes on the next enabled cycle
      cnt_next    = '0;
    end else if (en) begin
      if (cnt_reg == '0) begin
        tick     = 1'b1;
        cnt_next = reload_reg;
      end else begin
        cnt_next = cnt_reg - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      reload_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      reload_reg <= reload_next;
    end
  end

endmodule : strobe_divider

// File: rtl/strobe_pattern_gen.sv
// -----------------------------------------------------------------------------
// strobe_pattern_gen
//   On-chip stimulus source for the strobed sample interface. A run emits
//   `length` samples of an impulse, step, ramp or square pattern, each
//   qualified by a one-cycle strobe, one sample every `period` clocks.
//   Run parameters are captured when the run is accepted and are not
//   affected by later input changes.
//
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; low freezes all state and masks strobe_out
//   start      in   level-sampled start request (accepted only in IDLE)
//   abort      in   stop the current run without signalling done
//   mode       in   00 impulse, 01 step, 10 ramp, 11 square
//   amplitude  in   pulse/step/square level, ramp increment
//   period     in   clocks between strobes (below 2 treated as 2)
//   length     in   samples per run
//   mark_idx   in   impulse/step position, square half-period (0 -> 1)
//   data_out   out  registered sample word, held between strobes
//   strobe_out out  one-cycle sample-valid pulse
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse at normal run completion
// -----------------------------------------------------------------------------
module strobe_pattern_gen #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  length,
  input  logic [CNT_W-1:0]  mark_idx,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              busy,
  output logic              done
);
  import pattern_gen_pkg::*;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg,    state_next;
  mode_t             mode_reg,     mode_next;
  logic [DATA_W-1:0] amp_reg,      amp_next;
  logic [CNT_W-1:0]  len_reg,      len_next;
  logic [CNT_W-1:0]  mark_reg,     mark_next;
  logic [CNT_W-1:0]  half_reg,     half_next;     // square half-period, never 0
  logic [CNT_W-1:0]  idx_reg,      idx_next;      // samples emitted so far
  logic [DATA_W-1:0] acc_reg,      acc_next;      // ramp accumulator
  logic [CNT_W-1:0]  sq_cnt_reg,   sq_cnt_next;   // position inside half-period
  logic              sq_phase_reg, sq_phase_next; // 0 = low half, 1 = high half
  logic [DATA_W-1:0] data_reg,     data_next;
  logic              strobe_reg,   strobe_next;

  logic              accept;
  logic              div_en;
  logic              tick;
  logic [DATA_W-1:0] sample_val;

  // A start is accepted only from IDLE while enabled; abort has priority.
  assign accept = ena && (state_reg == IDLE) && start && !abort;

  // The divider only runs inside a run; an abort cycle must not produce a tick
  // because the run ends on that same edge.
  assign div_en = ena && (state_reg == RUN) && !abort;

  strobe_divider #(
    .CNT_W (CNT_W)
  ) u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .en     (div_en),
    .period (period),
    .tick   (tick)
  );

  // ---------------------------------------------------------------------------
  // Value of the sample about to be emitted (index idx_reg)
  // ---------------------------------------------------------------------------
  always_comb begin
    sample_val = '0;
    unique case (mode_reg)
      IMPULSE: sample_val = (idx_reg == mark_reg) ? amp_reg : '0;
      STEP:    sample_val = (idx_reg >= mark_reg) ? amp_reg : '0;
      RAMP:    sample_val = acc_reg;
      SQUARE:  sample_val = sq_phase_reg ? amp_reg : '0;
      default: sample_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    amp_next      = amp_reg;
    len_next      = len_reg;
    mark_next     = mark_reg;
    half_next     = half_reg;
    idx_next      = idx_reg;
    acc_next      = acc_reg;
    sq_cnt_next   = sq_cnt_reg;
    sq_phase_next = sq_phase_reg;
    data_next     = data_reg;
    strobe_next   = 1'b0;

    if (ena) begin
      unique case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            mode_next     = mode_t'(mode);
            amp_next      = amplitude;
            len_next      = length;
            mark_next     = mark_idx;
            half_next     = (mark_idx == '0) ? ONE : mark_idx;
            idx_next      = '0;
            acc_next      = '0;
            sq_cnt_next   = '0;
            sq_phase_next = 1'b0;
            state_next    = (length == '0) ? DONE : RUN;
          end
        end

        RUN: begin
          if (abort) begin
            state_next = IDLE;
            data_next  = '0;
          end else if (tick) begin
            if (idx_reg == len_reg) begin
              // The tick one period after the last sample closes the run.
              state_next = DONE;
            end else begin
              strobe_next = 1'b1;
              data_next   = sample_val;
              idx_next    = idx_reg + ONE;
              acc_next    = acc_reg + amp_reg;   // wraps modulo 2^DATA_W
              if (sq_cnt_reg == half_reg - ONE) begin
                sq_cnt_next   = '0;
                sq_phase_next = ~sq_phase_reg;
              end else begin
                sq_cnt_next = sq_cnt_reg + ONE;
              end
            end
          end
        end

        DONE: begin
          // start is deliberately not looked at here
          state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mode_reg     <= IMPULSE;
      amp_reg      <= '0;
      len_reg      <= '0;
      mark_reg     <= '0;
      half_reg     <= ONE;
      idx_reg      <= '0;
      acc_reg      <= '0;
      sq_cnt_reg   <= '0;
      sq_phase_reg <= 1'b0;
      data_reg     <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      amp_reg      <= amp_next;
      len_reg      <= len_next;
      mark_reg     <= mark_next;
      half_reg     <= half_next;
      idx_reg      <= idx_next;
      acc_reg      <= acc_next;
      sq_cnt_reg   <= sq_cnt_next;
      sq_phase_reg <= sq_phase_next;
      data_reg     <= data_next;
      strobe_reg   <= strobe_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out = data_reg;
  // strobe_reg clears on the first frozen edge; the ena mask also hides a
  // strobe already registered when ena drops in its cycle.
  assign strobe_out = strobe_reg & ena;
  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE) & ena;

endmodule : strobe_pattern_gen

// File: tb/tb_strobe_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_strobe_pattern_gen
//   Directed bench for strobe_pattern_gen. Each run is planned up front into
//   per-cycle expectation arrays (strobe, data, busy, done) derived from the
//   run timing rules; a compare process checks the DUT against them on every
//   cycle. Literal sequences from hand calculation pin the plan.
// -----------------------------------------------------------------------------
module tb_strobe_pattern_gen;

  localparam int MAXC = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [9:0] amplitude = '0;
  logic [7:0] period = '0;
  logic [7:0] length = '0;
  logic [7:0] mark_idx = '0;
  logic [9:0] data_out;
  logic       strobe_out;
  logic       busy;
  logic       done;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // expectation for the cycle following edge e lives at index e
  int exp_strobe [MAXC];
  int exp_busy   [MAXC];
  int exp_done   [MAXC];
  int exp_data   [MAXC];
  bit ena_lo     [MAXC];   // edges at which ena is driven low

  int cap_q[$];
  int cap_e[$];
  int done_e[$];

  strobe_pattern_gen #(
    .DATA_W (10),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .amplitude  (amplitude),
    .period     (period),
    .length     (length),
    .mark_idx   (mark_idx),
    .data_out   (data_out),
    .strobe_out (strobe_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int model_val(input int md, input int amp, input int mark, input int n);
    int m;
    case (md)
      0:       return (n == mark) ? amp : 0;
      1:       return (n >= mark) ? amp : 0;
      2:       return (n * amp) % 1024;
      default: begin
        m = (mark == 0) ? 1 : mark;
        return (((n / m) % 2) == 1) ? amp : 0;
      end
    endcase
  endfunction

  // edge at which the given number of enabled clocks after edge k has elapsed
  function automatic int step_edge(input int k, input int steps);
    int e = k;
    int s = 0;
    while (s < steps && e < MAXC - 1) begin
      e++;
      if (!ena_lo[e]) s++;
    end
    return e;
  endfunction

  task automatic fill_data(input int e, input int v);
    for (int i = e; i < MAXC; i++) exp_data[i] = v;
  endtask

  task automatic clear_from(input int e, input int v);
    for (int i = e; i < MAXC; i++) begin
      exp_strobe[i] = 0;
      exp_busy[i]   = 0;
      exp_done[i]   = 0;
      exp_data[i]   = v;
    end
  endtask

  task automatic plan_run(input int k, input int md, input int amp, input int per,
                          input int len, input int mark, input int abort_at,
                          output int d);
    int p;
    int e;
    int lim;
    p   = (per < 2) ? 2 : per;
    lim = (abort_at > 0) ? abort_at : MAXC;
    for (int n = 0; n < len; n++) begin
      e = step_edge(k, 1 + n * p);
      if (e < lim) begin
        exp_strobe[e] = 1;
        fill_data(e, model_val(md, amp, mark, n));
      end
    end
    d = step_edge(k, 1 + len * p);
    if (abort_at > 0) begin
      for (int i = k; i < abort_at; i++) exp_busy[i] = 1;
      fill_data(abort_at, 0);
      d = abort_at;
    end else begin
      for (int i = k; i < d; i++) exp_busy[i] = 1;
      exp_done[d] = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare and capture processes
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < MAXC) begin
      check("strobe_out", int'(strobe_out), exp_strobe[cyc]);
      check("data_out",   int'(data_out),   exp_data[cyc]);
      check("busy",       int'(busy),       exp_busy[cyc]);
      check("done",       int'(done),       exp_done[cyc]);
    end
  end

  always @(negedge clk) begin
    if (strobe_out) begin
      cap_q.push_back(int'(data_out));
      cap_e.push_back(cyc);
    end
    if (done) done_e.push_back(cyc);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    ena = (cyc + 1 < MAXC) ? !ena_lo[cyc + 1] : 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_run(input int md, input int amp, input int per, input int len,
                           input int mark, input int abort_n,
                           output int k, output int d);
    int p;
    int ab;
    mode      = md[1:0];
    amplitude = amp[9:0];
    period    = per[7:0];
    length    = len[7:0];
    mark_idx  = mark[7:0];
    start     = 1'b1;
    k  = cyc + 1;
    p  = (per < 2) ? 2 : per;
    ab = (abort_n >= 0) ? (k + 1 + abort_n * p + 1) : 0;
    cap_q.delete();
    cap_e.delete();
    done_e.delete();
    plan_run(k, md, amp, per, len, mark, ab, d);
    step();
    start = 1'b0;
    // inputs changed mid-run must have no effect
    amplitude = 10'($urandom);
    period    = 8'($urandom_range(0, 9));
    mark_idx  = 8'($urandom_range(0, 9));
    mode      = 2'($urandom);
  endtask

  task automatic report(input string name);
    $display("run %-10s strobes=%0d done_pulses=%0d", name, cap_q.size(), done_e.size());
  endtask

  task automatic check_seq(input string name, input int ref_q[$]);
    check({name, "_count"}, cap_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++)
      check({name, "_value"}, cap_q[i], ref_q[i]);
  endtask

  task automatic check_gaps(input string name, input int p);
    for (int i = 1; i < cap_e.size(); i++)
      check({name, "_gap"}, cap_e[i] - cap_e[i-1], p);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int d;
    int nz;
    int nb;
    int dd;
    int bb;
    int ref_q[$];

    repeat (2) @(negedge clk);
    check("reset_data",   int'(data_out),   0);
    check("reset_strobe", int'(strobe_out), 0);
    check("reset_busy",   int'(busy),       0);
    check("reset_done",   int'(done),       0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();
    step();

    // impulse
    start_run(0, 1023, 2, 50, 10, -1, k, d);
    wait_until(d + 2);
    report("impulse");
    check("imp_count", cap_q.size(), 50);
    nz = 0;
    foreach (cap_q[i]) if (cap_q[i] != 0) nz++;
    check("imp_nonzero", nz, 1);
    if (cap_q.size() == 50) begin
      check("imp_peak", cap_q[10], 1023);
      check("imp_done_gap", (done_e.size() > 0) ? done_e[0] - cap_e[49] : -1, 2);
    end
    check_gaps("imp", 2);

    // step
    start_run(1, 512, 4, 6, 3, -1, k, d);
    wait_until(d + 2);
    report("step");
    ref_q = {0, 0, 0, 512, 512, 512};
    check_seq("step", ref_q);
    check_gaps("step", 4);
    if (cap_e.size() > 0) check("step_first_latency", cap_e[0] - k, 1);

    // ramp with wrap
    start_run(2, 300, 3, 5, 0, -1, k, d);
    wait_until(d + 2);
    report("ramp");
    ref_q = {0, 300, 600, 900, 176};
    check_seq("ramp", ref_q);
    check_gaps("ramp", 3);

    // square
    start_run(3, 100, 2, 6, 2, -1, k, d);
    wait_until(d + 2);
    report("square_m2");
    ref_q = {0, 0, 100, 100, 0, 0};
    check_seq("sq2", ref_q);

    start_run(3, 100, 2, 6, 0, -1, k, d);
    wait_until(d + 2);
    report("square_m0");
    ref_q = {0, 100, 0, 100, 0, 100};
    check_seq("sq0", ref_q);

    // period clamp
    start_run(1, 5, 0, 4, 0, -1, k, d);
    wait_until(d + 2);
    report("period0");
    check_gaps("per0", 2);
    start_run(1, 6, 1, 4, 0, -1, k, d);
    wait_until(d + 2);
    report("period1");
    check_gaps("per1", 2);
    check("per1_count", cap_q.size(), 4);

    // ena low for three edges where strobe 2 falls due
    for (int i = 0; i < 3; i++) ena_lo[cyc + 10 + i] = 1'b1;
    start_run(2, 7, 4, 6, 0, -1, k, d);
    wait_until(d + 2);
    report("ena_gap");
    ref_q = {0, 7, 14, 21, 28, 35};
    check_seq("ena", ref_q);
    if (cap_e.size() >= 4) begin
      check("ena_gap01", cap_e[1] - cap_e[0], 4);
      check("ena_gap12", cap_e[2] - cap_e[1], 7);
      check("ena_gap23", cap_e[3] - cap_e[2], 4);
    end

    // abort one clock after strobe 5
    start_run(2, 1, 3, 20, 0, 5, k, d);
    wait_until(k + 1 + 5 * 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(d + 10);
    report("abort");
    ref_q = {0, 1, 2, 3, 4, 5};
    check_seq("abort", ref_q);
    check("abort_done_pulses", done_e.size(), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_data", int'(data_out), 0);

    // length 0: done, no strobe, never busy
    chk_en = 1'b0;
    cap_q.delete();
    cap_e.delete();
    done_e.delete();
    mode = 2'b01; amplitude = 10'd77; period = 8'd3; length = 8'd0; mark_idx = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) nb++;
      step();
    end
    report("length0");
    check("len0_done_pulses", done_e.size(), 1);
    check("len0_strobes", cap_q.size(), 0);
    check("len0_busy_cycles", nb, 0);

    // start held high through DONE
    cap_q.delete();
    cap_e.delete();
    done_e.delete();
    mode = 2'b01; amplitude = 10'd9; period = 8'd2; length = 8'd3; mark_idx = 8'd0;
    start = 1'b1;
    dd = -1;
    bb = -1;
    for (int i = 0; i < 60 && dd < 0; i++) begin
      step();
      if (done) dd = cyc;
    end
    for (int i = 0; i < 20 && dd >= 0 && bb < 0; i++) begin
      step();
      if (busy) bb = cyc;
    end
    start = 1'b0;
    check("held_first_done_seen", int'(dd >= 0), 1);
    check("held_restart_seen", int'(bb >= 0), 1);
    repeat (30) step();
    report("start_held");
    check("held_done_pulses", done_e.size(), 2);
    check("held_strobes", cap_q.size(), 6);
    check("held_busy_end", int'(busy), 0);
    check("held_restart_window", int'(bb == dd + 1 || bb == dd + 2), 1);
    if (cap_e.size() >= 4) check("held_restart_latency", cap_e[3] - bb, 1);
    clear_from(cyc, 9);
    chk_en = 1'b1;
    step();
    step();

    // asynchronous reset mid-run
    start_run(2, 2, 3, 10, 0, -1, k, d);
    wait_until(k + 8);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_data", int'(data_out), 4);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset_data",   int'(data_out),   0);
    check("async_reset_strobe", int'(strobe_out), 0);
    check("async_reset_busy",   int'(busy),       0);
    check("async_reset_done",   int'(done),       0);
    step();
    clear_from(cyc, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (6) step();
    report("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_strobe_pattern_gen
